// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state encodings,
// default reset PC and the sequential fetch-PC increment.
package ifu_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_REQ    = 2'd1,
    FETCH_WAIT   = 2'd2,
    FETCH_CANCEL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'hBFC0_0000;

  // An 8-byte aligned PC fetches two words; an odd-word PC only reaches the
  // end of the 8-byte group, so it advances by one word. Wraps modulo 2^32.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] cur_pc);
    return cur_pc + (cur_pc[2] ? 32'd4 : 32'd8);
  endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_redirect_buf.sv
// Holding register for a redirect that arrives while a bus address is still
// un-acknowledged; a later redirect overwrites an earlier one.
module ifu_redirect_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic [31:0] set_pc,
  input  logic        clr,
  output logic        pend_vld,
  output logic [31:0] pend_pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (set) begin
      pend_vld <= 1'b1;
      pend_pc  <= set_pc;
    end else if (clr) begin
      pend_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding SRAM-like request, 1-2 words per
// fetch group, redirects absorbed anywhere. Optional counters: IFU_FETCH_PERF_EN.
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_ena,
  input  logic [31:0] redirect_pc,
  input  logic        ifq_ready,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata_1,
  input  logic [31:0] inst_rdata_2,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst_1,
  output logic [31:0] fetch_inst_2,
  output logic        fetch_inst_2_valid
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic         capture, drop, pend_set, pend_clr;
  logic         pend_vld;
  logic [31:0]  pend_pc;

  logic         vld_p1;
  logic [31:0]  fetch_pc_p1, inst_1_p1, inst_2_p1;
  logic         inst_2_vld_p1;

  ifu_redirect_buf u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .set      (pend_set),
    .set_pc   (redirect_pc),
    .clr      (pend_clr),
    .pend_vld (pend_vld),
    .pend_pc  (pend_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    inst_req  = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (redirect_ena) pc_nxt = redirect_pc;
        if (ifq_ready)    state_nxt = FETCH_REQ;
      end
      FETCH_REQ: begin
        inst_req = 1'b1;
        if (inst_addr_ok) begin
          pend_clr = 1'b1;
          // A redirect in the accept cycle is newer than anything buffered.
          if (redirect_ena) begin
            pc_nxt    = redirect_pc;
            state_nxt = FETCH_CANCEL;
          end else if (pend_vld) begin
            pc_nxt    = pend_pc;
            state_nxt = FETCH_CANCEL;
          end else begin
            state_nxt = FETCH_WAIT;
          end
        end else if (redirect_ena) begin
          pend_set = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (redirect_ena) begin
          pc_nxt = redirect_pc;
          if (inst_data_ok) begin
            drop      = 1'b1;
            state_nxt = ifq_ready ? FETCH_REQ : FETCH_IDLE;
          end else begin
            state_nxt = FETCH_CANCEL;
          end
        end else if (inst_data_ok) begin
          capture   = 1'b1;
          pc_nxt    = next_fetch_pc(pc_q);
          state_nxt = ifq_ready ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_CANCEL: begin
        if (redirect_ena) pc_nxt = redirect_pc;
        if (inst_data_ok) begin
          drop      = 1'b1;
          state_nxt = ifq_ready ? FETCH_REQ : FETCH_IDLE;
        end
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  // p1: registered fetch group, valid for the cycle after the accepted data_ok
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      vld_p1        <= 1'b0;
      fetch_pc_p1   <= '0;
      inst_1_p1     <= '0;
      inst_2_p1     <= '0;
      inst_2_vld_p1 <= 1'b0;
    end else begin
      pc_q   <= pc_nxt;
      vld_p1 <= capture;
      if (capture) begin
        fetch_pc_p1   <= pc_q;
        inst_1_p1     <= inst_rdata_1;
        inst_2_p1     <= inst_rdata_2;
        inst_2_vld_p1 <= ~pc_q[2];
      end
    end
  end

  assign inst_addr          = pc_q;
  assign pc                 = pc_q;
  assign fetch_valid        = vld_p1;
  assign fetch_pc           = fetch_pc_p1;
  assign fetch_inst_1       = inst_1_p1;
  assign fetch_inst_2       = inst_2_p1;
  assign fetch_inst_2_valid = inst_2_vld_p1;

`ifdef IFU_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_cancel_cnt <= '0;
    end else begin
      if (capture) perf_fetch_cnt  <= sat_inc32(perf_fetch_cnt);
      if (drop)    perf_cancel_cnt <= sat_inc32(perf_cancel_cnt);
    end
  end
`endif

endmodule
